// File: rtl/alu_operand_pipe.sv
// alu_operand_pipe: B-operand select with forwarding, word-mode sign extension and a registered valid/ready stage
module alu_operand_pipe #(
    parameter int XLEN = 64,
    parameter int NSRC = 4,
    parameter int NFWD = 2,
    parameter int SELW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SELW-1:0]      in_sel,
    input  logic [NSRC*XLEN-1:0] in_src,
    input  logic [4:0]           in_rs_idx,
    input  logic                 in_word,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*5-1:0]    fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_data,
    output logic                 out_fwd_hit,
    output logic [15:0]          stall_cnt
);
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] fwd_val;
    logic [XLEN-1:0] operand;
    logic            hit;
    logic            load;
    logic            valid_q, valid_d;
    logic            hit_q, hit_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [15:0]     stall_q, stall_d;

    // source mux; selects beyond NSRC-1 fall back to the register value
    always_comb begin
        raw = in_src[XLEN-1:0];
        for (int k = 1; k < NSRC; k++)
            raw = (in_sel == SELW'(k)) ? in_src[k*XLEN +: XLEN] : raw;
    end

    // forwarding override, scanned from the last port so port 0 wins; x0 never forwards
    always_comb begin
        fwd_val = raw;
        hit     = 1'b0;
        for (int p = NFWD - 1; p >= 0; p--)
            if (in_sel == '0 && in_rs_idx != 5'd0 && fwd_valid[p] && fwd_rd[p*5 +: 5] == in_rs_idx) begin
                fwd_val = fwd_data[p*XLEN +: XLEN];
                hit     = 1'b1;
            end
    end

    // RV64 word mode sign-extends the low 32 bits
    always_comb operand = in_word ? {{(XLEN-32){fwd_val[31]}}, fwd_val[31:0]} : fwd_val;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // next state: flush beats load, load beats drain; stall counter saturates
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        hit_d   = hit_q;
        stall_d = (valid_q && !out_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        if (flush)
            valid_d = 1'b0;
        else if (load) begin
            valid_d = 1'b1;
            data_d  = operand;
            hit_d   = hit;
        end else if (out_ready)
            valid_d = 1'b0;
    end

    // pipeline register with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            hit_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            hit_q   <= hit_d;
            stall_q <= stall_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_fwd_hit = hit_q;
    assign stall_cnt   = stall_q;
endmodule

// File: tb/tb_alu_operand_pipe.sv
// tb_alu_operand_pipe: directed and randomized checks of alu_operand_pipe against a behavioural model
module tb_alu_operand_pipe;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid, in_ready, in_word, flush, out_valid, out_ready, out_fwd_hit;
    logic [1:0]   in_sel;
    logic [4:0]   in_rs_idx;
    logic [1:0]   fwd_valid;
    logic [63:0]  src [4];
    logic [4:0]   frd [2];
    logic [63:0]  fd [2];
    logic [255:0] in_src;
    logic [9:0]   fwd_rd;
    logic [127:0] fwd_data;
    logic [63:0]  out_data;
    logic [15:0]  stall_cnt;
    int           total = 0;
    int           bad = 0;
    logic         m_valid;
    logic [63:0]  m_data;
    logic         m_hit;
    int           m_stall;
    logic [63:0]  sel_exp [4];

    always #5 clk = ~clk;

    assign in_src   = {src[3], src[2], src[1], src[0]};
    assign fwd_rd   = {frd[1], frd[0]};
    assign fwd_data = {fd[1], fd[0]};

    alu_operand_pipe dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_src(in_src), .in_rs_idx(in_rs_idx), .in_word(in_word),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_fwd_hit(out_fwd_hit), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // operand as the rules describe it: pick, forward from first matching port, then word-extend
    function automatic logic [63:0] ref_operand(output logic h);
        logic [63:0] v;
        h = 1'b0;
        v = src[in_sel];
        if (in_sel == 2'd0 && in_rs_idx != 5'd0)
            for (int p = 0; p < 2; p++)
                if (!h && fwd_valid[p] && frd[p] == in_rs_idx) begin
                    v = fd[p];
                    h = 1'b1;
                end
        if (in_word) v = {{32{v[31]}}, v[31:0]};
        return v;
    endfunction

    task automatic check_outs();
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_fwd_hit", out_fwd_hit, m_hit);
        end
        chk("stall_cnt", stall_cnt, 64'(m_stall));
    endtask

    task automatic cycle();
        logic [63:0] nd;
        logic        nh, rdy;
        #1;
        rdy = !m_valid || out_ready;
        chk("in_ready", in_ready, rdy);
        nd = ref_operand(nh);
        if (m_valid && !out_ready) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        if (flush) m_valid = 1'b0;
        else if (in_valid && rdy) begin
            m_valid = 1'b1;
            m_data  = nd;
            m_hit   = nh;
        end else if (out_ready) m_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic rand_inputs();
        in_valid  = 1'($urandom);
        in_sel    = 2'($urandom);
        in_rs_idx = 5'($urandom_range(0, 7));
        in_word   = ($urandom_range(0, 3) == 0);
        fwd_valid = 2'($urandom);
        flush     = ($urandom_range(0, 15) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 4; k++) src[k] = {$urandom, $urandom};
        for (int p = 0; p < 2; p++) begin
            frd[p] = 5'($urandom_range(0, 7));
            fd[p]  = {$urandom, $urandom};
        end
    endtask

    // asserts reset between edges; outputs must clear before any clock edge
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        m_valid = 1'b0;
        m_data  = '0;
        m_hit   = 1'b0;
        m_stall = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_hit", out_fwd_hit, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("rst_valid_clk", out_valid, 0);
        chk("rst_stall_clk", stall_cnt, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        rand_inputs();
        do_reset();
        in_valid = 1'b1;
        flush    = 1'b0;
        cycle();
        chk("first_req_valid", out_valid, 1);

        sel_exp = '{64'h1234, 64'hFFFF_FFFF_FFFF_FFF0, 64'h3, 64'h8000_0000};
        for (int k = 0; k < 4; k++) src[k] = sel_exp[k];
        fwd_valid = 2'b00;
        in_word   = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            cycle();
            chk("sel_const", out_data, sel_exp[s]);
        end

        in_sel    = 2'd0;
        in_rs_idx = 5'd5;
        fwd_valid = 2'b11;
        frd[0]    = 5'd5;
        frd[1]    = 5'd5;
        fd[0]     = 64'hAAAA;
        fd[1]     = 64'hBBBB;
        cycle();
        chk("fwd_prio_data", out_data, 64'hAAAA);
        chk("fwd_prio_hit", out_fwd_hit, 1);
        in_rs_idx = 5'd0;
        cycle();
        chk("fwd_x0_data", out_data, 64'h1234);
        chk("fwd_x0_hit", out_fwd_hit, 0);
        in_rs_idx = 5'd5;
        in_sel    = 2'd1;
        cycle();
        chk("fwd_sel1_data", out_data, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("fwd_sel1_hit", out_fwd_hit, 0);
        fwd_valid = 2'b10;
        in_sel    = 2'd0;
        cycle();
        chk("fwd_port1_data", out_data, 64'hBBBB);

        fwd_valid = 2'b00;
        in_word   = 1'b1;
        src[0]    = 64'h0000_0000_8000_0001;
        cycle();
        chk("word_neg", out_data, 64'hFFFF_FFFF_8000_0001);
        src[0] = 64'h1_7FFF_FFFF;
        cycle();
        chk("word_pos", out_data, 64'h7FFF_FFFF);
        in_word = 1'b0;

        do_reset();
        src[0]    = 64'h1111;
        out_ready = 1'b0;
        cycle();
        repeat (5) cycle();
        chk("bp_in_ready", in_ready, 0);
        chk("bp_data", out_data, 64'h1111);
        chk("bp_stall", stall_cnt, 5);
        out_ready = 1'b1;
        src[0]    = 64'h2222;
        cycle();
        chk("bp_reload_valid", out_valid, 1);
        chk("bp_reload_data", out_data, 64'h2222);

        out_ready = 1'b0;
        flush     = 1'b1;
        src[0]    = 64'h4444;
        cycle();
        chk("flush_valid", out_valid, 0);
        flush    = 1'b0;
        in_valid = 1'b0;
        cycle();
        chk("flush_dropped", out_valid, 0);
        in_valid = 1'b1;
        cycle();
        cycle();
        chk("hold_before_rst", out_valid, 1);
        do_reset();
        cycle();
        chk("after_rst_req", out_valid, 1);

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end

        rand_inputs();
        do_reset();
        in_valid  = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        cycle();
        repeat (65534) cycle();
        chk("sat_fffe", stall_cnt, 64'hFFFE);
        cycle();
        chk("sat_ffff", stall_cnt, 64'hFFFF);
        repeat (5) cycle();
        chk("sat_hold", stall_cnt, 64'hFFFF);
        flush = 1'b1;
        cycle();
        chk("sat_flush_keeps", stall_cnt, 64'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_operand_pipe.md
Name: alu_operand_pipe

Overview:
- Parametrised successor to the ALU B-operand select stage.
- Selects one of NSRC operand sources: register read, sign-extended immediate, shamt, pc, and so on.
- Overrides the register source with forwarded results from up to NFWD later pipeline stages, and optionally applies RV64 word-mode sign extension.
- Registers the result in a one-entry valid/ready pipeline stage between decode and execute.

Parameters:
- XLEN, 64, operand width in bits.
- NSRC, 4, number of selectable sources; source 0 is always the register-file value.
- NFWD, 2, number of forwarding ports; port 0 has the highest priority.
- SELW, $clog2(NSRC), width of the select field (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has an operand request.
- in_ready  out  1  stage can accept a request this cycle.
- in_sel  in  SELW  source select.
- in_src  in  NSRC*XLEN  flattened sources; source k is bits [k*XLEN +: XLEN].
- in_rs_idx  in  5  architectural register index of source 0.
- in_word  in  1  word mode: sign-extend bit 31 of the selected value to XLEN.
- fwd_valid  in  NFWD  forwarding port carries a valid result.
- fwd_rd  in  NFWD*5  destination register index per port.
- fwd_data  in  NFWD*XLEN  result data per port.
- flush  in  1  squash the held and incoming request.
- out_valid  out  1  registered operand valid.
- out_ready  in  1  downstream accepts the operand.
- out_data  out  XLEN  registered operand.
- out_fwd_hit  out  1  registered operand came from a forwarding port.
- stall_cnt  out  16  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (reset_n=0, asynchronous): out_valid=0, out_data=0, out_fwd_hit=0, stall_cnt=0. in_ready is combinational and reads 1 during reset.
- in_ready = !out_valid || out_ready. This is combinational, with no bubble when downstream drains every cycle.
- Load: on a rising edge with in_valid && in_ready && !flush:
  - out_valid<=1.
  - out_data<=final operand.
  - out_fwd_hit<=the forwarding decision.
- Drain: on a rising edge with out_valid && out_ready and no load, out_valid<=0. out_data and out_fwd_hit hold their previous values.
- Hold: when out_valid && !out_ready, all registered outputs hold. in_ready=0 in this case, and upstream must keep its request stable.
- Flush: has priority over load and hold. On the next edge out_valid<=0, and any incoming request that cycle is dropped. out_data is don't-care after a flush.
- Source select:
  - raw = source in_sel.
  - If in_sel >= NSRC (possible when NSRC is not a power of two), raw = source 0.
- Forwarding:
  - Applies only when in_sel==0 and in_rs_idx!=0.
  - The lowest-numbered port p with fwd_valid[p] && fwd_rd[p]==in_rs_idx supplies the value, and the hit flag is set.
  - Otherwise raw is used and the hit flag is 0.
  - Register x0 never forwards.
- Word mode: if in_word, the final operand = {{(XLEN-32){sel[31]}}, sel[31:0]}, where sel is the value after forwarding. Otherwise the final operand = sel unchanged.
- Latency: exactly 1 cycle from an accepted request to out_valid.
- Throughput: 1 operand per cycle while out_ready=1.
- stall_cnt:
  - Increments by 1 each edge where out_valid && !out_ready.
  - Saturates at 16'hFFFF.
  - Cleared only by reset, not by flush.
- Simultaneous drain and load in the same edge: the new operand replaces the old, and out_valid stays 1.
- Reset asserted mid-transfer clears everything immediately. The first request after reset_n rises is accepted normally.

Test Plan:
- Reset: drive reset_n=0 with random inputs -> out_valid=0, out_data=0, stall_cnt=0, in_ready=1. Then release reset and issue one request -> out_valid=1 the next cycle.
- Source select (XLEN=64, NSRC=4): set in_src = {pc=0x80000000, shamt=0x3, imm=0xFFFF_FFFF_FFFF_FFF0, rs=0x1234}. Issue in_sel=0..3 back-to-back with out_ready=1 -> out_data is 0x1234, 0xFF..F0, 0x3, 0x80000000 on consecutive cycles, with no bubbles.
- Forwarding priority: in_sel=0, in_rs_idx=5, fwd_valid=2'b11, fwd_rd={5,5}, fwd_data={0xBBBB, 0xAAAA} (port 0 = 0xAAAA) -> out_data=0xAAAA, out_fwd_hit=1.
  - Same stimulus with in_rs_idx=0 -> source 0 is used, out_fwd_hit=0.
  - Same stimulus with in_sel=1 -> no forwarding.
- Word mode: in_sel=0, rs=0x0000_0000_8000_0001, in_word=1 -> out_data=0xFFFF_FFFF_8000_0001.
  - rs=0x1_7FFF_FFFF with in_word=1 -> out_data=0x7FFF_FFFF.
- Backpressure: load one operand, hold out_ready=0 for 5 cycles -> in_ready=0, out_data stable, stall_cnt=5. Then set out_ready=1 with in_valid=1 -> the new operand loads on the same edge.
  - Force stall_cnt to 0xFFFF -> it stays at 0xFFFF.
- Flush: with out_valid=1 and out_ready=0, assert flush together with in_valid=1 -> out_valid=0 the next cycle and the incoming request is not loaded. Then assert reset_n=0 mid-hold -> out_valid drops asynchronously, without waiting for a clock edge.
